// File: rtl/hpdcache_mem_arb_pkg.sv
// Shared widths, helpers and default-configuration transaction types for the
// HPDcache memory read arbiter.
package hpdcache_mem_arb_pkg;

   function automatic int idx_width(input int nports);
      return (nports <= 2) ? 1 : $clog2(nports);
   endfunction

   function automatic int cnt_width(input int max_outst);
      return $clog2(max_outst + 1);
   endfunction

   localparam int DEF_NPORTS = 2;
   localparam int DEF_ADDR_W = 64;
   localparam int DEF_ID_W   = 4;
   localparam int DEF_DATA_W = 128;
   localparam int DEF_IDX_W  = idx_width(DEF_NPORTS);

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]          addr;
      logic [DEF_IDX_W+DEF_ID_W-1:0] id;
   } mem_req_t;

   typedef struct packed {
      logic [DEF_IDX_W+DEF_ID_W-1:0] id;
      logic [DEF_DATA_W-1:0]         data;
      logic                          last;
   } mem_rsp_t;

endpackage

// File: rtl/hpdcache_mem_rd_arb_chk.sv
// Protocol checks for the read arbiter: counter underflow and grant sanity.
module hpdcache_mem_rd_arb_chk #(
   parameter int NPORTS = 2
) (
   input logic              clk_i,
   input logic              rst_ni,
   input logic              underflow,
   input logic [NPORTS-1:0] req_ready,
   input logic [NPORTS-1:0] eligible
);

   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow);

   a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready));

   a_ready_eligible: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_ready & ~eligible) == {NPORTS{1'b0}});

endmodule

// File: rtl/hpdcache_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer itself is owned by the parent.
module hpdcache_rr_arbiter
   import hpdcache_mem_arb_pkg::*;
#(
   parameter int  NPORTS = 2,
   localparam int IDX_W  = idx_width(NPORTS)
) (
   input  logic [NPORTS-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic              gnt_valid,
   output logic [IDX_W-1:0]  gnt_idx
);

   // Pick the requester with the smallest wrapped distance from the pointer
   always_comb begin
      int best_s;
      int dist_s;
      logic take_s;
      best_s  = NPORTS;
      dist_s  = 0;
      take_s  = 1'b0;
      gnt_idx = {IDX_W{1'b0}};
      for (int p = 0; p < NPORTS; p++) begin
         dist_s  = (p >= int'(ptr)) ? (p - int'(ptr)) : (p - int'(ptr) + NPORTS);
         take_s  = req[p] && (dist_s < best_s);
         best_s  = take_s ? dist_s : best_s;
         gnt_idx = take_s ? IDX_W'(p) : gnt_idx;
      end
      gnt_valid = (best_s < NPORTS);
   end

endmodule

// File: rtl/hpdcache_mem_rd_arb.sv
// N-port read-request arbiter with per-port outstanding limits, drain mode and
// zero-latency response routing back to the owning port.
module hpdcache_mem_rd_arb
   import hpdcache_mem_arb_pkg::*;
#(
   parameter int  NPORTS    = 2,
   parameter int  ADDR_W    = 64,
   parameter int  ID_W      = 4,
   parameter int  DATA_W    = 128,
   parameter int  MAX_OUTST = 4,
   localparam int IDX_W     = idx_width(NPORTS),
   localparam int CNT_W     = cnt_width(MAX_OUTST)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NPORTS-1:0]              req_valid_i,
   output logic [NPORTS-1:0]              req_ready_o,
   input  logic [NPORTS-1:0][ADDR_W-1:0]  req_addr_i,
   input  logic [NPORTS-1:0][ID_W-1:0]    req_id_i,
   output logic [NPORTS-1:0]              rsp_valid_o,
   input  logic [NPORTS-1:0]              rsp_ready_i,
   output logic [ID_W-1:0]                rsp_id_o,
   output logic [DATA_W-1:0]              rsp_data_o,
   output logic                           rsp_last_o,
   output logic                           mem_req_valid_o,
   input  logic                           mem_req_ready_i,
   output logic [ADDR_W-1:0]              mem_req_addr_o,
   output logic [IDX_W+ID_W-1:0]          mem_req_id_o,
   input  logic                           mem_rsp_valid_i,
   output logic                           mem_rsp_ready_o,
   input  logic [IDX_W+ID_W-1:0]          mem_rsp_id_i,
   input  logic [DATA_W-1:0]              mem_rsp_data_i,
   input  logic                           mem_rsp_last_i,
   input  logic                           drain_i,
   output logic                           idle_o,
   output logic                           err_o
);

   logic [NPORTS-1:0][CNT_W-1:0] cnt_r;
   logic                         out_valid_r;
   logic [ADDR_W-1:0]            out_addr_r;
   logic [IDX_W+ID_W-1:0]        out_id_r;
   logic [IDX_W-1:0]             rr_ptr_r;
   logic                         err_r;

   logic [NPORTS-1:0]            eligible_s;
   logic                         gnt_valid_s;
   logic [IDX_W-1:0]             gnt_idx_s;
   logic                         grant_s;
   logic [ADDR_W-1:0]            sel_addr_s;
   logic [ID_W-1:0]              sel_id_s;
   logic [NPORTS-1:0]            inc_s;
   logic [NPORTS-1:0]            dec_s;
   logic [IDX_W-1:0]             rsp_port_s;
   logic                         rsp_in_range_s;
   logic                         rsp_accept_s;
   logic                         underflow_s;

   // Eligibility, grant qualification and selected request payload
   always_comb begin
      for (int p = 0; p < NPORTS; p++) begin
         eligible_s[p] = req_valid_i[p] && (cnt_r[p] < CNT_W'(MAX_OUTST)) && !drain_i;
      end
      grant_s    = (!out_valid_r || mem_req_ready_i) && gnt_valid_s;
      sel_addr_s = {ADDR_W{1'b0}};
      sel_id_s   = {ID_W{1'b0}};
      for (int p = 0; p < NPORTS; p++) begin
         inc_s[p]       = grant_s && (gnt_idx_s == IDX_W'(p));
         req_ready_o[p] = inc_s[p];
         sel_addr_s     = (gnt_idx_s == IDX_W'(p)) ? req_addr_i[p] : sel_addr_s;
         sel_id_s       = (gnt_idx_s == IDX_W'(p)) ? req_id_i[p]   : sel_id_s;
      end
   end

   hpdcache_rr_arbiter #(
      .NPORTS (NPORTS)
   ) u_rr_arbiter (
      .req       (eligible_s),
      .ptr       (rr_ptr_r),
      .gnt_valid (gnt_valid_s),
      .gnt_idx   (gnt_idx_s)
   );

   // Response routing; an out-of-range port index is swallowed (ready stays high)
   always_comb begin
      rsp_port_s      = mem_rsp_id_i[IDX_W+ID_W-1:ID_W];
      rsp_in_range_s  = ({1'b0, rsp_port_s} < (IDX_W+1)'(NPORTS));
      mem_rsp_ready_o = 1'b1;
      for (int p = 0; p < NPORTS; p++) begin
         rsp_valid_o[p]  = mem_rsp_valid_i && (rsp_port_s == IDX_W'(p));
         mem_rsp_ready_o = (rsp_port_s == IDX_W'(p)) ? rsp_ready_i[p] : mem_rsp_ready_o;
      end
      rsp_accept_s = mem_rsp_valid_i && mem_rsp_ready_o;
      underflow_s  = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
         dec_s[p]    = rsp_accept_s && mem_rsp_last_i && (rsp_port_s == IDX_W'(p))
                       && (cnt_r[p] != {CNT_W{1'b0}});
         underflow_s = underflow_s || (rsp_accept_s && mem_rsp_last_i
                       && (rsp_port_s == IDX_W'(p)) && (cnt_r[p] == {CNT_W{1'b0}}));
      end
   end

   assign rsp_id_o        = mem_rsp_id_i[ID_W-1:0];
   assign rsp_data_o      = mem_rsp_data_i;
   assign rsp_last_o      = mem_rsp_last_i;
   assign mem_req_valid_o = out_valid_r;
   assign mem_req_addr_o  = out_addr_r;
   assign mem_req_id_o    = out_id_r;
   assign idle_o          = !out_valid_r && (cnt_r == {(NPORTS*CNT_W){1'b0}});
   assign err_o           = err_r;

   // One-entry output register and round-robin pointer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_r <= 1'b0;
         out_addr_r  <= {ADDR_W{1'b0}};
         out_id_r    <= {(IDX_W+ID_W){1'b0}};
         rr_ptr_r    <= {IDX_W{1'b0}};
      end else if (grant_s) begin
         out_valid_r <= 1'b1;
         out_addr_r  <= sel_addr_s;
         out_id_r    <= {gnt_idx_s, sel_id_s};
         rr_ptr_r    <= (gnt_idx_s == IDX_W'(NPORTS-1)) ? {IDX_W{1'b0}}
                                                         : gnt_idx_s + IDX_W'(1'b1);
      end else if (mem_req_ready_i) begin
         out_valid_r <= 1'b0;
      end
   end

   // Per-port outstanding counters; simultaneous grant and last beat cancel out
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= {(NPORTS*CNT_W){1'b0}};
      end else begin
         for (int p = 0; p < NPORTS; p++) begin
            case ({inc_s[p], dec_s[p]})
               2'b10:   cnt_r[p] <= cnt_r[p] + CNT_W'(1'b1);
               2'b01:   cnt_r[p] <= cnt_r[p] - CNT_W'(1'b1);
               default: cnt_r[p] <= cnt_r[p];
            endcase
         end
      end
   end

   // Error pulse for each dropped beat carrying a nonexistent port index
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_r <= 1'b0;
      end else begin
         err_r <= mem_rsp_valid_i && !rsp_in_range_s;
      end
   end

   hpdcache_mem_rd_arb_chk #(
      .NPORTS (NPORTS)
   ) u_chk (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .underflow (underflow_s),
      .req_ready (req_ready_o),
      .eligible  (eligible_s)
   );

endmodule

// File: tb/tb_hpdcache_mem_rd_arb.sv
// Randomized bench for hpdcache_mem_rd_arb against a transaction-level model
// (3 ports so an out-of-range response index exists, limit of 2 outstanding).
module tb_hpdcache_mem_rd_arb;

   localparam int NP = 3;
   localparam int AW = 32;
   localparam int IW = 4;
   localparam int DW = 32;
   localparam int MO = 2;
   localparam int XW = 2;

   logic                   clk = 1'b0;
   logic                   rst_ni;
   logic [NP-1:0]          req_valid_i;
   logic [NP-1:0]          req_ready_o;
   logic [NP-1:0][AW-1:0]  req_addr_i;
   logic [NP-1:0][IW-1:0]  req_id_i;
   logic [NP-1:0]          rsp_valid_o;
   logic [NP-1:0]          rsp_ready_i;
   logic [IW-1:0]          rsp_id_o;
   logic [DW-1:0]          rsp_data_o;
   logic                   rsp_last_o;
   logic                   mem_req_valid_o;
   logic                   mem_req_ready_i;
   logic [AW-1:0]          mem_req_addr_o;
   logic [XW+IW-1:0]       mem_req_id_o;
   logic                   mem_rsp_valid_i;
   logic                   mem_rsp_ready_o;
   logic [XW+IW-1:0]       mem_rsp_id_i;
   logic [DW-1:0]          mem_rsp_data_i;
   logic                   mem_rsp_last_i;
   logic                   drain_i;
   logic                   idle_o;
   logic                   err_o;

   always #5 clk = ~clk;

   hpdcache_mem_rd_arb #(
      .NPORTS(NP), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .MAX_OUTST(MO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_id_i(req_id_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
      .mem_rsp_id_i(mem_rsp_id_i), .mem_rsp_data_i(mem_rsp_data_i),
      .mem_rsp_last_i(mem_rsp_last_i),
      .drain_i(drain_i), .idle_o(idle_o), .err_o(err_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: pending memory request, next-preferred port, in-flight count per port
   bit              m_valid;
   logic [AW-1:0]   m_addr;
   logic [XW+IW-1:0] m_id;
   int              m_ptr;
   int              m_cnt [NP];
   bit              m_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_addr  = '0;
      m_id    = '0;
      m_ptr   = 0;
      m_err   = 1'b0;
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
   endtask

   task automatic idle_inputs();
      req_valid_i     = '0;
      req_addr_i      = '0;
      req_id_i        = '0;
      rsp_ready_i     = '0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_id_i    = '0;
      mem_rsp_data_i  = '0;
      mem_rsp_last_i  = 1'b0;
      drain_i         = 1'b0;
   endtask

   task automatic check_reset_state();
      chk("rst_mem_req_valid", mem_req_valid_o, 0);
      chk("rst_mem_req_addr", mem_req_addr_o, 0);
      chk("rst_mem_req_id", mem_req_id_o, 0);
      chk("rst_idle", idle_o, 1);
      chk("rst_err", err_o, 0);
      chk("rst_req_ready", req_ready_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_mem_rsp_ready", mem_rsp_ready_o, 0);
   endtask

   // Round robin: the eligible port with the smallest forward distance from m_ptr
   function automatic int pick(input bit [NP-1:0] elig, input int ptr);
      for (int k = 0; k < NP; k++) begin
         if (elig[(ptr + k) % NP]) return (ptr + k) % NP;
      end
      return -1;
   endfunction

   task automatic drive(input int pv, input int pr, input int prsp, input int pd);
      int start;
      int port;
      for (int p = 0; p < NP; p++) begin
         req_valid_i[p] = ($urandom % 100) < pv;
         req_addr_i[p]  = $urandom;
         req_id_i[p]    = IW'($urandom);
         rsp_ready_i[p] = ($urandom % 100) < 70;
      end
      mem_req_ready_i = ($urandom % 100) < pr;
      drain_i         = ($urandom % 100) < pd;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_id_i    = XW+IW'($urandom);
      mem_rsp_data_i  = $urandom;
      mem_rsp_last_i  = $urandom % 2;
      port            = -1;
      if (($urandom % 100) < prsp) begin
         if (($urandom % 20) == 0) begin
            port = 3;
         end else begin
            start = $urandom % NP;
            for (int k = 0; k < NP; k++) begin
               if (port < 0 && m_cnt[(start + k) % NP] > 0) port = (start + k) % NP;
            end
         end
      end
      if (port >= 0) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_id_i    = {XW'(port), IW'($urandom)};
      end
   endtask

   task automatic check_cycle();
      bit [NP-1:0] elig;
      bit [NP-1:0] exp_ready;
      bit [NP-1:0] exp_rv;
      bit          inrange;
      bit          exp_mr;
      bit          dec;
      int          g;
      int          port;
      int          total;
      chk("mem_req_valid", mem_req_valid_o, m_valid);
      if (m_valid) begin
         chk("mem_req_addr", mem_req_addr_o, m_addr);
         chk("mem_req_id", mem_req_id_o, m_id);
      end
      for (int p = 0; p < NP; p++) elig[p] = req_valid_i[p] && (m_cnt[p] < MO) && !drain_i;
      g = (!m_valid || mem_req_ready_i) ? pick(elig, m_ptr) : -1;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready_o, exp_ready);

      port    = int'(mem_rsp_id_i[XW+IW-1:IW]);
      inrange = port < NP;
      exp_rv  = '0;
      if (mem_rsp_valid_i && inrange) exp_rv[port] = 1'b1;
      exp_mr  = inrange ? rsp_ready_i[port] : 1'b1;
      chk("rsp_valid", rsp_valid_o, exp_rv);
      chk("mem_rsp_ready", mem_rsp_ready_o, exp_mr);
      chk("rsp_id", rsp_id_o, mem_rsp_id_i[IW-1:0]);
      chk("rsp_data", rsp_data_o, mem_rsp_data_i);
      chk("rsp_last", rsp_last_o, mem_rsp_last_i);
      total = 0;
      for (int p = 0; p < NP; p++) total += m_cnt[p];
      chk("idle", idle_o, !m_valid && total == 0);
      chk("err", err_o, m_err);

      dec = mem_rsp_valid_i && exp_mr && inrange && mem_rsp_last_i && m_cnt[port] > 0;
      if (dec) m_cnt[port]--;
      if (g >= 0) begin
         m_valid = 1'b1;
         m_addr  = req_addr_i[g];
         m_id    = {XW'(g), req_id_i[g]};
         m_ptr   = (g + 1) % NP;
         m_cnt[g]++;
      end else if (mem_req_ready_i) begin
         m_valid = 1'b0;
      end
      m_err = mem_rsp_valid_i && !inrange;
   endtask

   task automatic run(input int n, input int pv, input int pr, input int prsp, input int pd);
      repeat (n) begin
         @(posedge clk);
         #1;
         drive(pv, pr, prsp, pd);
         @(negedge clk);
         check_cycle();
      end
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state();
      rst_ni = 1'b1;

      run(100, 95, 100, 0, 0);    // saturate limits with no responses
      run(300, 60, 70, 60, 10);   // mixed traffic
      run(200, 90, 20, 50, 0);    // heavy memory backpressure
      run(200, 50, 80, 70, 40);   // frequent drain
      run(150, 0, 100, 90, 0);    // drain everything out

      @(posedge clk);
      #1;
      idle_inputs();
      rst_ni = 1'b0;
      @(negedge clk);
      check_reset_state();
      model_reset();
      rst_ni = 1'b1;

      run(300, 70, 80, 60, 15);
      run(100, 0, 100, 90, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
